// File: rtl/branch_fetch_ctl.sv
// branch_fetch_ctl
//   Front-end fetch sequencer with an integrated branch unit. Owns the fetch
//   PC and presents SLOTS-aligned group addresses to instruction memory. It
//   tracks in-flight groups through a MEM_LAT-deep tag pipeline, decodes B
//   instructions (opcode 3'b001) in the returned group, and redirects on a
//   taken branch or an external redirect. Wrong-path slots are squashed with
//   per-slot valid masks.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   fetch_en         : advance enable; 0 freezes all state
//   ir_in            : returned group, slot k = ir_in[16k+15:16k]
//   redirect_in      : external redirect request (held until fetch_en)
//   redirect_pc_in   : external redirect target, any alignment
//   pc_out           : aligned fetch address presented to memory
//   group_pc_out     : address of the group currently on ir_in
//   slot_valid_out   : per-slot issue valid for the current group
//   br_taken_out     : a B instruction is taken in the current group
//   br_slot_out      : slot index of the taken B
//   br_target_out    : unaligned branch target (0 when nothing is taken)
module branch_fetch_ctl #(
  parameter int PC_W     = 9,
  parameter int IMM_W    = 8,
  parameter int SLOTS    = 2,
  parameter int MEM_LAT  = 1,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic [16*SLOTS-1:0]  ir_in,
  input  logic                 redirect_in,
  input  logic [PC_W-1:0]      redirect_pc_in,
  output logic [PC_W-1:0]      pc_out,
  output logic [PC_W-1:0]      group_pc_out,
  output logic [SLOTS-1:0]     slot_valid_out,
  output logic                 br_taken_out,
  output logic [1:0]           br_slot_out,
  output logic [PC_W-1:0]      br_target_out
);

  localparam int OFF_W = $clog2(SLOTS);
  localparam int HEAD  = MEM_LAT - 1;

  // Fetch PC and the entry offset of the group being fetched right now
  // (non-zero only for the first group after a redirect to an odd target).
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [OFF_W-1:0] cur_off_q, cur_off_d;

  // Tag pipeline: entry 0 is the youngest, entry HEAD describes ir_in.
  logic             vld_q  [MEM_LAT];
  logic             vld_d  [MEM_LAT];
  logic [PC_W-1:0]  addr_q [MEM_LAT];
  logic [PC_W-1:0]  addr_d [MEM_LAT];
  logic [OFF_W-1:0] off_q  [MEM_LAT];
  logic [OFF_W-1:0] off_d  [MEM_LAT];

  logic             head_vld;
  logic [PC_W-1:0]  head_addr;
  logic [OFF_W-1:0] head_off;

  logic [SLOTS-1:0] base_vld;
  logic [SLOTS-1:0] is_br;
  logic [PC_W-1:0]  slot_tgt [SLOTS];

  logic             br_taken;
  logic [1:0]       br_slot;
  logic [PC_W-1:0]  br_tgt;
  logic [SLOTS-1:0] slot_vld;

  logic             take_redir;
  logic [PC_W-1:0]  redir_tgt;

  assign head_vld  = vld_q[HEAD];
  assign head_addr = addr_q[HEAD];
  assign head_off  = off_q[HEAD];

  // Per-slot decode: base validity, branch detect and target adder.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    localparam logic [PC_W-1:0]  NEXT_OFF = PC_W'(gi + 1);
    localparam logic [OFF_W-1:0] SLOT_IDX = OFF_W'(gi);

    logic [15:0]     ir_k;
    logic [PC_W-1:0] imm_ext;

    assign ir_k = ir_in[16*gi +: 16];

    if (IMM_W < PC_W) begin : g_sext
      assign imm_ext = {{(PC_W-IMM_W){ir_k[IMM_W-1]}}, ir_k[IMM_W-1:0]};
    end else begin : g_noext
      assign imm_ext = ir_k[PC_W-1:0];
    end

    // Operand bits between the offset field and the opcode are not decoded.
    if (IMM_W < 13) begin : g_gap
      logic unused_ir_bits;
      assign unused_ir_bits = ^ir_k[12:IMM_W];
    end

    assign base_vld[gi] = head_vld && (SLOT_IDX >= head_off);
    assign is_br[gi]    = base_vld[gi] && (ir_k[15:13] == 3'b001);
    assign slot_tgt[gi] = head_addr + NEXT_OFF + imm_ext;
  end

  // Lowest-index branch wins; everything after it in the group is dropped.
  always_comb begin
    br_taken = 1'b0;
    br_slot  = '0;
    br_tgt   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (is_br[i]) begin
        br_taken = 1'b1;
        br_slot  = 2'(i);
        br_tgt   = slot_tgt[i];
      end
    end
    slot_vld = base_vld;
    for (int i = 0; i < SLOTS; i++) begin
      if (br_taken && (2'(i) > br_slot)) begin
        slot_vld[i] = 1'b0;
      end
    end
  end

  // Next-state: the external redirect outranks a taken branch for the PC.
  // On any redirect, every in-flight group (including the one fetched at
  // this edge) is marked invalid; the target is fetched on the next edge
  // carrying its low bits as entry offset.
  always_comb begin
    pc_d      = pc_q;
    cur_off_d = cur_off_q;
    for (int i = 0; i < MEM_LAT; i++) begin
      vld_d[i]  = vld_q[i];
      addr_d[i] = addr_q[i];
      off_d[i]  = off_q[i];
    end

    take_redir = redirect_in || br_taken;
    redir_tgt  = redirect_in ? redirect_pc_in : br_tgt;

    if (fetch_en) begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        vld_d[i]  = vld_q[i-1] && !take_redir;
        addr_d[i] = addr_q[i-1];
        off_d[i]  = off_q[i-1];
      end
      vld_d[0]  = !take_redir;
      addr_d[0] = pc_q;
      off_d[0]  = cur_off_q;

      if (take_redir) begin
        pc_d      = {redir_tgt[PC_W-1:OFF_W], {OFF_W{1'b0}}};
        cur_off_d = redir_tgt[OFF_W-1:0];
      end else begin
        pc_d      = pc_q + PC_W'(SLOTS);
        cur_off_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_W'(RESET_PC);
      cur_off_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
        off_q[i]  <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      cur_off_q <= cur_off_d;
      for (int i = 0; i < MEM_LAT; i++) begin
        vld_q[i]  <= vld_d[i];
        addr_q[i] <= addr_d[i];
        off_q[i]  <= off_d[i];
      end
    end
  end

  assign pc_out         = pc_q;
  assign group_pc_out   = head_addr;
  assign slot_valid_out = slot_vld;
  assign br_taken_out   = br_taken;
  assign br_slot_out    = br_slot;
  assign br_target_out  = br_tgt;

endmodule

// File: tb/tb_branch_fetch_ctl.sv
// Bench for branch_fetch_ctl: directed vector tables for the default
// (SLOTS=2, MEM_LAT=1) and wide (SLOTS=4, MEM_LAT=3) configurations, then
// randomized runs against an epoch-tagged reference model.
module tb_branch_fetch_ctl;

  logic        clk;
  logic        rst;
  logic        fe;
  logic [63:0] ir;
  logic        rd;
  logic [8:0]  rpc;

  logic [8:0]  pc_a, gpc_a, tgt_a;
  logic [1:0]  vld_a;
  logic        tk_a;
  logic [1:0]  sl_a;

  logic [8:0]  pc_b, gpc_b, tgt_b;
  logic [3:0]  vld_b;
  logic        tk_b;
  logic [1:0]  sl_b;

  int n_tests = 0;
  int n_fail  = 0;

  branch_fetch_ctl dut_a (
    .clk(clk), .rst(rst), .fetch_en(fe), .ir_in(ir[31:0]),
    .redirect_in(rd), .redirect_pc_in(rpc),
    .pc_out(pc_a), .group_pc_out(gpc_a), .slot_valid_out(vld_a),
    .br_taken_out(tk_a), .br_slot_out(sl_a), .br_target_out(tgt_a)
  );

  branch_fetch_ctl #(.SLOTS(4), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .fetch_en(fe), .ir_in(ir),
    .redirect_in(rd), .redirect_pc_in(rpc),
    .pc_out(pc_b), .group_pc_out(gpc_b), .slot_valid_out(vld_b),
    .br_taken_out(tk_b), .br_slot_out(sl_b), .br_target_out(tgt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          fe;
    logic [63:0] ir;
    bit          rd;
    logic [8:0]  rpc;
    logic [8:0]  pc;
    logic [3:0]  vld;
    bit          tk;
    logic [1:0]  sl;
    logic [8:0]  tgt;
    logic [8:0]  gpc;
    bit          strict;  // also require br_slot/br_target = 0 when not taken
  } vec_t;

  vec_t tab_a [23];
  vec_t tab_b [10];

  function automatic vec_t mkv(bit r, bit f, logic [63:0] i, bit d, logic [8:0] p,
                               logic [8:0] epc, logic [3:0] ev, bit et, logic [1:0] es,
                               logic [8:0] etg, logic [8:0] eg, bit st);
    vec_t v;
    v.rst = r; v.fe = f; v.ir = i; v.rd = d; v.rpc = p;
    v.pc = epc; v.vld = ev; v.tk = et; v.sl = es; v.tgt = etg; v.gpc = eg; v.strict = st;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic get_act(input int which, output logic [31:0] apc, output logic [31:0] avld,
                         output logic [31:0] atk, output logic [31:0] asl,
                         output logic [31:0] atgt, output logic [31:0] agpc);
    if (which == 0) begin
      apc = 32'(pc_a); avld = 32'(vld_a); atk = 32'(tk_a);
      asl = 32'(sl_a); atgt = 32'(tgt_a); agpc = 32'(gpc_a);
    end else begin
      apc = 32'(pc_b); avld = 32'(vld_b); atk = 32'(tk_b);
      asl = 32'(sl_b); atgt = 32'(tgt_b); agpc = 32'(gpc_b);
    end
  endtask

  task automatic run_vec(input vec_t v, input int which, input int idx);
    logic [31:0] apc, avld, atk, asl, atgt, agpc;
    rst = v.rst; fe = v.fe; ir = v.ir; rd = v.rd; rpc = v.rpc;
    @(negedge clk);
    get_act(which, apc, avld, atk, asl, atgt, agpc);
    $display("[TB] %s row %0d pc=%0h vld=%0h tk=%0d sl=%0d tgt=%0h gpc=%0h",
             which == 0 ? "A" : "B", idx, apc, avld, atk, asl, atgt, agpc);
    chk("pc_out", idx, apc, 32'(v.pc));
    chk("slot_valid", idx, avld, 32'(v.vld));
    chk("br_taken", idx, atk, 32'(v.tk));
    chk("group_pc", idx, agpc, 32'(v.gpc));
    if (v.tk || v.strict) begin
      chk("br_slot", idx, asl, 32'(v.sl));
      chk("br_target", idx, atgt, 32'(v.tgt));
    end
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  // Every fetch is tagged with the redirect epoch current when it was issued;
  // a returned group is live only if no redirect happened since its fetch.
  typedef struct { int addr; int off; int ep; } fetch_t;
  fetch_t inflight [$];
  int m_pc, m_off, m_ep;

  task automatic model_reset(input int lat);
    fetch_t f;
    f.addr = 0; f.off = 0; f.ep = 0;
    inflight.delete();
    for (int i = 0; i < lat; i++) inflight.push_back(f);
    m_pc = 0; m_off = 0; m_ep = 1;
  endtask

  task automatic model_eval(input int slots, input logic [63:0] irv, output int mask,
                            output bit tk, output int sl, output int tgt);
    fetch_t h;
    bit hv;
    logic [15:0] w;
    int imm;
    h = inflight[0];
    hv = (h.ep == m_ep);
    mask = 0; tk = 0; sl = 0; tgt = 0;
    for (int k = 0; k < slots; k++) begin
      if (hv && k >= h.off && !tk) begin
        w = irv[16*k +: 16];
        mask = mask | (1 << k);
        if (w[15:13] == 3'b001) begin
          imm = int'(w[7:0]);
          if (imm >= 128) imm = imm - 256;
          tk = 1; sl = k;
          tgt = (h.addr + k + 1 + imm + 512) % 512;
        end
      end
    end
  endtask

  task automatic model_advance(input int slots, input bit rdv, input int rpcv,
                               input bit tk, input int tgt);
    fetch_t f;
    int t;
    f.addr = m_pc; f.off = m_off; f.ep = m_ep;
    inflight.push_back(f);
    void'(inflight.pop_front());
    if (rdv || tk) begin
      t = rdv ? rpcv : tgt;
      m_ep++;
      m_off = t % slots;
      m_pc = t - m_off;
    end else begin
      m_pc = (m_pc + slots) % 512;
      m_off = 0;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(3) == 0) w[15:13] = 3'b001;
    else if (w[15:13] == 3'b001) w[15:13] = 3'b000;
    return w;
  endfunction

  task automatic rand_phase(input int which, input int slots, input int lat, input int n);
    logic [31:0] apc, avld, atk, asl, atgt, agpc;
    int mask, sl, tgt;
    bit tk;
    rst = 1'b1; fe = 1'b0; rd = 1'b0; rpc = '0; ir = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset(lat);
    for (int c = 0; c < n; c++) begin
      rst = ($urandom_range(99) == 0);
      fe  = ($urandom_range(3) != 0);
      rd  = ($urandom_range(9) == 0);
      rpc = 9'($urandom);
      ir  = {rand_instr(), rand_instr(), rand_instr(), rand_instr()};
      @(negedge clk);
      model_eval(slots, ir, mask, tk, sl, tgt);
      get_act(which, apc, avld, atk, asl, atgt, agpc);
      $display("[TB] rnd %s c=%0d rst=%0d fe=%0d rd=%0d pc=%0h vld=%0h tk=%0d",
               which == 0 ? "A" : "B", c, rst, fe, rd, apc, avld, atk);
      chk("rnd_pc", c, apc, 32'(m_pc));
      chk("rnd_valid", c, avld, 32'(mask));
      chk("rnd_taken", c, atk, 32'(tk));
      chk("rnd_gpc", c, agpc, 32'(inflight[0].addr));
      if (tk) begin
        chk("rnd_slot", c, asl, 32'(sl));
        chk("rnd_target", c, atgt, 32'(tgt));
      end
      @(posedge clk); #1;
      if (rst) model_reset(lat);
      else if (fe) model_advance(slots, rd, int'(rpc), tk, tgt);
    end
  endtask

  initial begin
    // Default configuration: reset, slot-0 branch, odd target, stall,
    // redirect priority, reset mid-operation.
    tab_a[0]  = mkv(1,1,64'h0,     0,9'h00, 9'h00,4'h0,0,0,9'h00,9'h00,1);
    tab_a[1]  = mkv(0,1,64'h0,     0,9'h00, 9'h00,4'h0,0,0,9'h00,9'h00,1);
    tab_a[2]  = mkv(0,1,64'h0,     0,9'h00, 9'h02,4'h3,0,0,9'h00,9'h00,0);
    tab_a[3]  = mkv(0,1,64'h0,     0,9'h00, 9'h04,4'h3,0,0,9'h00,9'h02,0);
    tab_a[4]  = mkv(0,1,64'h2007,  0,9'h00, 9'h06,4'h1,1,0,9'h0c,9'h04,0);
    tab_a[5]  = mkv(0,1,64'h0,     0,9'h00, 9'h0c,4'h0,0,0,9'h00,9'h06,0);
    tab_a[6]  = mkv(0,1,64'h0,     0,9'h00, 9'h0e,4'h3,0,0,9'h00,9'h0c,0);
    tab_a[7]  = mkv(0,1,64'h0,     0,9'h00, 9'h10,4'h3,0,0,9'h00,9'h0e,0);
    tab_a[8]  = mkv(0,1,64'h20ff0000,0,9'h00,9'h12,4'h3,1,1,9'h11,9'h10,0);
    tab_a[9]  = mkv(0,1,64'h0,     0,9'h00, 9'h10,4'h0,0,0,9'h00,9'h12,0);
    tab_a[10] = mkv(0,1,64'h0,     0,9'h00, 9'h12,4'h2,0,0,9'h00,9'h10,0);
    tab_a[11] = mkv(0,0,64'h2003,  0,9'h00, 9'h14,4'h1,1,0,9'h16,9'h12,0);
    tab_a[12] = mkv(0,0,64'h2003,  0,9'h00, 9'h14,4'h1,1,0,9'h16,9'h12,0);
    tab_a[13] = mkv(0,0,64'h2003,  0,9'h00, 9'h14,4'h1,1,0,9'h16,9'h12,0);
    tab_a[14] = mkv(0,1,64'h2003,  0,9'h00, 9'h14,4'h1,1,0,9'h16,9'h12,0);
    tab_a[15] = mkv(0,1,64'h2003,  0,9'h00, 9'h16,4'h0,0,0,9'h00,9'h14,0);
    tab_a[16] = mkv(0,1,64'h0,     0,9'h00, 9'h18,4'h3,0,0,9'h00,9'h16,0);
    tab_a[17] = mkv(0,1,64'h20f3,  1,9'h31, 9'h1a,4'h1,1,0,9'h0c,9'h18,0);
    tab_a[18] = mkv(0,1,64'h0,     0,9'h00, 9'h30,4'h0,0,0,9'h00,9'h1a,0);
    tab_a[19] = mkv(0,1,64'h0,     0,9'h00, 9'h32,4'h2,0,0,9'h00,9'h30,0);
    tab_a[20] = mkv(1,1,64'h2007,  0,9'h00, 9'h34,4'h1,1,0,9'h3a,9'h32,0);
    tab_a[21] = mkv(0,1,64'h2007,  0,9'h00, 9'h00,4'h0,0,0,9'h00,9'h00,1);
    tab_a[22] = mkv(0,1,64'h0,     0,9'h00, 9'h02,4'h3,0,0,9'h00,9'h00,0);

    // Wide configuration: branches in slots 1 and 3, three bubbles, then
    // the target group entering at offset 2.
    tab_b[0] = mkv(1,1,64'h0,0,9'h00, 9'h00,4'h0,0,0,9'h00,9'h00,1);
    tab_b[1] = mkv(0,1,64'h0,0,9'h00, 9'h00,4'h0,0,0,9'h00,9'h00,1);
    tab_b[2] = mkv(0,1,64'h0,0,9'h00, 9'h04,4'h0,0,0,9'h00,9'h00,0);
    tab_b[3] = mkv(0,1,64'h0,0,9'h00, 9'h08,4'h0,0,0,9'h00,9'h00,0);
    tab_b[4] = mkv(0,1,64'h0,0,9'h00, 9'h0c,4'hf,0,0,9'h00,9'h00,0);
    tab_b[5] = mkv(0,1,64'h2005_0000_2010_0000,0,9'h00, 9'h10,4'h3,1,1,9'h16,9'h04,0);
    tab_b[6] = mkv(0,1,64'h2005_0000_2010_0000,0,9'h00, 9'h14,4'h0,0,0,9'h00,9'h08,0);
    tab_b[7] = mkv(0,1,64'h2005_0000_2010_0000,0,9'h00, 9'h18,4'h0,0,0,9'h00,9'h0c,0);
    tab_b[8] = mkv(0,1,64'h2005_0000_2010_0000,0,9'h00, 9'h1c,4'h0,0,0,9'h00,9'h10,0);
    tab_b[9] = mkv(0,1,64'h0,0,9'h00, 9'h20,4'hc,0,0,9'h00,9'h14,0);

    rst = 1'b1; fe = 1'b0; ir = '0; rd = 1'b0; rpc = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 23; i++) run_vec(tab_a[i], 0, i);

    rst = 1'b1; fe = 1'b0; ir = '0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) run_vec(tab_b[i], 1, i);

    rand_phase(0, 2, 1, 1500);
    rand_phase(1, 4, 3, 1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
